udcount_bus_master: RTL and testbench

- Upstream host-side sequencer for the programmable up/down counter.
- Accepts simple valid/ready commands (register write, register read, start pulse) and converts each into a correctly timed active-low chip-select/read/write bus cycle, or a one-cycle start strobe, on the counter's programming interface.
- Returns read data and completion status as a one-cycle response pulse.
- Sits between the test/host command source and the counter's a/din/dout/ncs/nwr/nrd/start pins.

---
 rtl/udcount_bus_master.sv | 177 +++++++++++++++++
 tb/tb_udcount_bus_master.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/udcount_bus_master.sv
// Host-side sequencer for the up/down counter programming port: turns valid/ready
// commands into timed ncs/nwr/nrd bus cycles or a start strobe, and returns a response pulse.
module udcount_bus_master #(
    parameter int ADDR_W     = 2,
    parameter int DATA_W     = 8,
    parameter int SETUP_CYC  = 1,
    parameter int STROBE_CYC = 2,
    parameter int HOLD_CYC   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    output logic              ncs,
    output logic              nwr,
    output logic              nrd,
    output logic [ADDR_W-1:0] a,
    output logic [DATA_W-1:0] din,
    input  logic [DATA_W-1:0] dout,
    output logic              start
);

    localparam int MAX_SU  = (SETUP_CYC > STROBE_CYC) ? SETUP_CYC : STROBE_CYC;
    localparam int MAX_CYC = (MAX_SU > HOLD_CYC) ? MAX_SU : HOLD_CYC;
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [CNT_W-1:0] SETUP_LD  = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] STROBE_LD = CNT_W'(STROBE_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(HOLD_CYC - 1);

    localparam logic [1:0] OP_WR    = 2'b00;
    localparam logic [1:0] OP_RD    = 2'b01;
    localparam logic [1:0] OP_START = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STROBE,
        HOLD,
        PULSE,
        RESP
    } state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [1:0]        op_q, op_nxt;
    logic              ncs_nxt, nwr_nxt, nrd_nxt, start_nxt;
    logic              rsp_valid_nxt, rsp_err_nxt;
    logic [DATA_W-1:0] rsp_data_nxt, din_nxt;
    logic [ADDR_W-1:0] a_nxt;

    assign cmd_ready = (state == IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            op_q      <= '0;
            ncs       <= 1'b1;
            nwr       <= 1'b1;
            nrd       <= 1'b1;
            start     <= 1'b0;
            a         <= '0;
            din       <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            op_q      <= op_nxt;
            ncs       <= ncs_nxt;
            nwr       <= nwr_nxt;
            nrd       <= nrd_nxt;
            start     <= start_nxt;
            a         <= a_nxt;
            din       <= din_nxt;
            rsp_valid <= rsp_valid_nxt;
            rsp_data  <= rsp_data_nxt;
            rsp_err   <= rsp_err_nxt;
        end
    end

    // Next-state logic produces the next value of every registered output.
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        op_nxt        = op_q;
        ncs_nxt       = ncs;
        nwr_nxt       = nwr;
        nrd_nxt       = nrd;
        start_nxt     = 1'b0;
        a_nxt         = a;
        din_nxt       = din;
        rsp_valid_nxt = 1'b0;
        rsp_data_nxt  = rsp_data;
        rsp_err_nxt   = 1'b0;

        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    op_nxt  = cmd_op;
                    a_nxt   = cmd_addr;
                    din_nxt = cmd_data;
                    case (cmd_op)
                        OP_WR, OP_RD: begin
                            state_nxt = SETUP;
                            ncs_nxt   = 1'b0;
                            cnt_nxt   = SETUP_LD;
                        end
                        OP_START: begin
                            state_nxt = PULSE;
                            start_nxt = 1'b1;
                        end
                        default: begin
                            state_nxt     = RESP;
                            rsp_valid_nxt = 1'b1;
                            rsp_err_nxt   = 1'b1;
                        end
                    endcase
                end
            end
            SETUP: begin
                if (cnt == '0) begin
                    state_nxt = STROBE;
                    cnt_nxt   = STROBE_LD;
                    nwr_nxt   = (op_q != OP_WR);
                    nrd_nxt   = (op_q != OP_RD);
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            STROBE: begin
                if (cnt == '0) begin
                    state_nxt = HOLD;
                    cnt_nxt   = HOLD_LD;
                    nwr_nxt   = 1'b1;
                    nrd_nxt   = 1'b1;
                    if (op_q == OP_RD)
                        rsp_data_nxt = dout;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            HOLD: begin
                if (cnt == '0) begin
                    state_nxt     = RESP;
                    ncs_nxt       = 1'b1;
                    rsp_valid_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            PULSE: begin
                state_nxt     = RESP;
                rsp_valid_nxt = 1'b1;
            end
            RESP: begin
                state_nxt    = IDLE;
                rsp_data_nxt = '0;
            end
            default: begin
                state_nxt = IDLE;
                ncs_nxt   = 1'b1;
                nwr_nxt   = 1'b1;
                nrd_nxt   = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_udcount_bus_master.sv
// Directed bench for udcount_bus_master: per-scenario tasks with hand-derived
// cycle-by-cycle expectations, plus a bus protocol monitor.
module tb_udcount_bus_master;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [1:0] cmd_addr;
    logic [7:0] cmd_data;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       rsp_err;
    logic       ncs, nwr, nrd;
    logic [1:0] a;
    logic [7:0] din;
    logic [7:0] dout;
    logic       start;

    int vectors    = 0;
    int miscompares = 0;

    udcount_bus_master dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_addr  (cmd_addr),
        .cmd_data  (cmd_data),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .ncs       (ncs),
        .nwr       (nwr),
        .nrd       (nrd),
        .a         (a),
        .din       (din),
        .dout      (dout),
        .start     (start)
    );

    always #5 clk = ~clk;

    // Protocol monitor: strobes never overlap, never outside ncs, address/data frozen under ncs.
    logic       prev_ncs = 1'b1;
    logic [1:0] prev_a   = '0;
    logic [7:0] prev_din = '0;
    always @(negedge clk) begin
        vectors++;
        if ((nwr === 1'b0 && nrd === 1'b0) || (ncs === 1'b1 && (nwr === 1'b0 || nrd === 1'b0))) begin
            miscompares++;
            $display("FAIL protocol_strobe ncs=%b nwr=%b nrd=%b required no overlap and strobe only under ncs",
                     ncs, nwr, nrd);
        end
        if (prev_ncs === 1'b0 && ncs === 1'b0 && (a !== prev_a || din !== prev_din)) begin
            miscompares++;
            $display("FAIL protocol_stable a=%h din=%h required a=%h din=%h while ncs low",
                     a, din, prev_a, prev_din);
        end
        prev_ncs = ncs;
        prev_a   = a;
        prev_din = din;
    end

    task automatic test_reset();
        rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_addr = '0; cmd_data = '0; dout = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if ({cmd_ready, ncs, nwr, nrd, start, rsp_valid, rsp_err} !== 7'b1111000 ||
            a !== 2'd0 || din !== 8'd0 || rsp_data !== 8'd0) begin
            miscompares++;
            $display("FAIL reset_state got rdy=%b ncs=%b nwr=%b nrd=%b start=%b rv=%b err=%b a=%h din=%h rd=%h required 1 1 1 1 0 0 0 0 00 00",
                     cmd_ready, ncs, nwr, nrd, start, rsp_valid, rsp_err, a, din, rsp_data);
        end
    endtask

    // Write (op 00) or read (op 01) bus cycle; k counts negedges after the accept edge.
    task automatic test_bus(input string name, input logic [1:0] op, input logic [1:0] addr,
                            input logic [7:0] data, input logic [7:0] rdval);
        logic       e_ncs, e_str, e_rv, e_rdy;
        logic [7:0] e_rd;
        logic       str, other;
        dout = ~rdval;
        cmd_valid = 1'b1; cmd_op = op; cmd_addr = addr; cmd_data = data;
        vectors++;
        if (cmd_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL %s ready_before got %b required 1", name, cmd_ready);
        end
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (k == 1) cmd_valid = 1'b0;
            if (op == 2'b01) dout = (k == 3) ? rdval : ~rdval;
            e_ncs = (k >= 5);
            e_str = !(k == 2 || k == 3);
            e_rv  = (k == 5);
            e_rdy = (k == 6);
            e_rd  = (k == 5 && op == 2'b01) ? rdval : 8'h00;
            str   = (op == 2'b00) ? nwr : nrd;
            other = (op == 2'b00) ? nrd : nwr;
            vectors++;
            if (ncs !== e_ncs || str !== e_str || other !== 1'b1) begin
                miscompares++;
                $display("FAIL %s bus k=%0d got ncs=%b strobe=%b other=%b required %b %b 1",
                         name, k, ncs, str, other, e_ncs, e_str);
            end
            vectors++;
            if (rsp_valid !== e_rv || cmd_ready !== e_rdy || rsp_err !== 1'b0 ||
                (e_rv && rsp_data !== e_rd) || (k == 6 && rsp_data !== 8'h00)) begin
                miscompares++;
                $display("FAIL %s rsp k=%0d got rv=%b rdy=%b err=%b data=%h required %b %b 0 %h",
                         name, k, rsp_valid, cmd_ready, rsp_err, rsp_data, e_rv, e_rdy, e_rd);
            end
            if (k <= 4) begin
                vectors++;
                if (a !== addr || din !== data) begin
                    miscompares++;
                    $display("FAIL %s addr_data k=%0d got a=%h din=%h required %h %h",
                             name, k, a, din, addr, data);
                end
            end
        end
    endtask

    task automatic test_start();
        cmd_valid = 1'b1; cmd_op = 2'b10; cmd_addr = 2'd3; cmd_data = 8'h11;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            if (k == 1) cmd_valid = 1'b0;
            vectors++;
            if (start !== (k == 1) || rsp_valid !== (k == 2) || ncs !== 1'b1 ||
                rsp_err !== 1'b0 || rsp_data !== 8'h00 || cmd_ready !== (k == 3)) begin
                miscompares++;
                $display("FAIL start_pulse k=%0d got start=%b rv=%b ncs=%b err=%b data=%h rdy=%b required %b %b 1 0 00 %b",
                         k, start, rsp_valid, ncs, rsp_err, rsp_data, cmd_ready, k == 1, k == 2, k == 3);
            end
        end
    endtask

    task automatic test_reserved();
        cmd_valid = 1'b1; cmd_op = 2'b11; cmd_addr = 2'd1; cmd_data = 8'hEE;
        for (int k = 1; k <= 2; k++) begin
            @(negedge clk);
            if (k == 1) cmd_valid = 1'b0;
            vectors++;
            if (rsp_valid !== (k == 1) || rsp_err !== (k == 1) || rsp_data !== 8'h00 ||
                ncs !== 1'b1 || start !== 1'b0 || cmd_ready !== (k == 2)) begin
                miscompares++;
                $display("FAIL reserved_op k=%0d got rv=%b err=%b data=%h ncs=%b start=%b rdy=%b required %b %b 00 1 0 %b",
                         k, rsp_valid, rsp_err, rsp_data, ncs, start, cmd_ready, k == 1, k == 1, k == 2);
            end
        end
    endtask

    // Command held valid continuously: responses must land on cycles 5 and 11.
    task automatic test_back_to_back();
        int accepts = 0;
        int rsp_seen = 0;
        int rsp_cyc[2];
        rsp_cyc[0] = 0; rsp_cyc[1] = 0;
        cmd_valid = 1'b1; cmd_op = 2'b00; cmd_addr = 2'd0; cmd_data = 8'hA5;
        for (int k = 0; k <= 12; k++) begin
            if (k > 0) @(negedge clk);
            if (cmd_valid && cmd_ready) begin
                accepts++;
                if (accepts == 2) begin
                    @(posedge clk);
                    @(negedge clk);
                    cmd_valid = 1'b0;
                    k++;
                end
            end
            if (rsp_valid === 1'b1 && rsp_seen < 2) begin
                rsp_cyc[rsp_seen] = k;
                rsp_seen++;
            end
        end
        cmd_valid = 1'b0;
        vectors++;
        if (rsp_seen !== 2 || rsp_cyc[0] !== 5 || rsp_cyc[1] !== 11) begin
            miscompares++;
            $display("FAIL back_to_back got %0d responses at cycles %0d,%0d required 2 at 5,11",
                     rsp_seen, rsp_cyc[0], rsp_cyc[1]);
        end
    endtask

    task automatic test_reset_abort();
        int rv_count = 0;
        cmd_valid = 1'b1; cmd_op = 2'b00; cmd_addr = 2'd3; cmd_data = 8'hC7;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        vectors++;
        if (nwr !== 1'b0 || ncs !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_in_strobe got nwr=%b ncs=%b required 0 0", nwr, ncs);
        end
        rst = 1'b1;
        #1;
        vectors++;
        if (nwr !== 1'b1 || ncs !== 1'b1 || a !== 2'd0 || din !== 8'd0) begin
            miscompares++;
            $display("FAIL abort_async got nwr=%b ncs=%b a=%h din=%h required 1 1 0 00", nwr, ncs, a, din);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0) rv_count++;
        end
        vectors++;
        if (rv_count !== 0 || cmd_ready !== 1'b1 || ncs !== 1'b1) begin
            miscompares++;
            $display("FAIL abort_no_rsp got %0d rsp pulses rdy=%b ncs=%b required 0 1 1", rv_count, cmd_ready, ncs);
        end
    endtask

    initial begin
        test_reset();
        test_bus("write_5a", 2'b00, 2'd2, 8'h5A, 8'h00);
        test_bus("read_3c", 2'b01, 2'd1, 8'h00, 8'h3C);
        test_bus("read_81", 2'b01, 2'd3, 8'h77, 8'h81);
        test_start();
        test_reserved();
        test_back_to_back();
        @(negedge clk);
        test_reset_abort();
        test_bus("write_after_rst", 2'b00, 2'd1, 8'hC3, 8'h00);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout simulation did not finish by 100000 time units");
        $fatal(1);
    end

endmodule
